// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multicycle control sequencer: state encoding,
// opcode constants, datapath select encodings and the opcode-class enum.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } seqState_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_LUI     = 3'd6,
        CLS_ILLEGAL = 3'd7
    } opClass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

endpackage

// File: rtl/seq_opclass_decode.sv
// Combinational opcode-to-class decoder; anything unrecognised is CLS_ILLEGAL.
module seq_opclass_decode
    import cpu_seq_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] opClass
);

    // Pure lookup of the 7-bit major opcode.
    always_comb begin
        opClass = CLS_ILLEGAL;
        case (opcode)
            OP_R:      opClass = CLS_R;
            OP_I:      opClass = CLS_I;
            OP_LOAD:   opClass = CLS_LOAD;
            OP_STORE:  opClass = CLS_STORE;
            OP_BRANCH: opClass = CLS_BRANCH;
            OP_JAL:    opClass = CLS_JAL;
            OP_LUI:    opClass = CLS_LUI;
            default:   opClass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a
// bounded data-memory wait and a retired-instruction counter.
// Build option: ILLEGAL_TRAP_EN -- illegal opcodes halt in TRAP instead of
// being retired as NOPs.
module multicycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        imem_valid,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        dmem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        bus_err,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam int CW = $clog2(DMEM_TIMEOUT + 1);

    seqState_t   stateReg;
    seqState_t   stateNext;
    logic [CW-1:0] memCount;
    logic [2:0]  opClassRaw;
    opClass_t    opClass;
    logic        memTimeout;
    logic        retire;

    seq_opclass_decode u_decode (
        .opcode  (opcode),
        .opClass (opClassRaw)
    );

    assign opClass    = opClass_t'(opClassRaw);
    assign state      = stateReg;
    // The timeout cycle is the one whose count equals DMEM_TIMEOUT; the
    // strobe is already dropped there, even if dmem_ready rescues it.
    assign memTimeout = (stateReg == ST_MEM) && (memCount == CW'(DMEM_TIMEOUT));

`ifdef ILLEGAL_TRAP_EN
    assign trap = (stateReg == ST_TRAP);
`else
    assign trap = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= ST_FETCH;
        end else begin
            stateReg <= stateNext;
        end
    end

    // MEM wait counter: 1 on the first MEM cycle, cleared outside MEM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memCount <= '0;
        end else if (stateReg == ST_EXECUTE && stateNext == ST_MEM) begin
            memCount <= CW'(1);
        end else if (stateReg == ST_MEM && stateNext == ST_MEM) begin
            memCount <= memCount + CW'(1);
        end else begin
            memCount <= '0;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_FETCH: begin
                if (run && imem_valid) stateNext = ST_DECODE;
            end
            ST_DECODE: stateNext = ST_EXECUTE;
            ST_EXECUTE: begin
                case (opClass)
                    CLS_R, CLS_I, CLS_LUI, CLS_JAL: stateNext = ST_WRITEBACK;
                    CLS_LOAD, CLS_STORE:            stateNext = ST_MEM;
                    CLS_BRANCH:                     stateNext = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
                    default:                        stateNext = ST_TRAP;
`else
                    default:                        stateNext = ST_FETCH;
`endif
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    stateNext = (opClass == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
                end else if (memTimeout) begin
                    stateNext = ST_FETCH;
                end
            end
            ST_WRITEBACK: stateNext = ST_FETCH;
            ST_TRAP:      stateNext = ST_TRAP;
            default:      stateNext = ST_FETCH;
        endcase
    end

    // Output decode from the registered state and the (stable) IR opcode.
    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_err   = 1'b0;
        retire    = 1'b0;
        case (stateReg)
            ST_FETCH: ir_write = run && imem_valid;
            ST_EXECUTE: begin
                case (opClass)
                    CLS_R: alu_op = ALU_FUNCT;
                    CLS_I: begin
                        alu_op    = ALU_FUNCT;
                        alu_src_b = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_op    = ALU_ADD;
                        alu_src_b = 1'b1;
                    end
                    CLS_LUI: begin
                        alu_op    = ALU_PASSB;
                        alu_src_b = 1'b1;
                    end
                    CLS_JAL: alu_op = ALU_ADD;
                    CLS_BRANCH: begin
                        alu_op   = ALU_SUB;
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
                        retire   = 1'b1;
                    end
                    default: begin
`ifndef ILLEGAL_TRAP_EN
                        pc_write = 1'b1;
                        retire   = 1'b1;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                mem_read  = (opClass == CLS_LOAD)  && !memTimeout;
                mem_write = (opClass == CLS_STORE) && !memTimeout;
                if (dmem_ready) begin
                    if (opClass == CLS_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end else if (memTimeout) begin
                    bus_err  = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                wb_sel    = (opClass == CLS_JAL)  ? WB_PC4 :
                            (opClass == CLS_LOAD) ? WB_MEM : WB_ALU;
                pc_src    = (opClass == CLS_JAL)  ? PC_JAL : PC_PLUS4;
            end
            default: ;
        endcase
    end

endmodule
